// File: rtl/map_write_arbiter_pkg.sv
// Shared display package: board geometry, card coding and map-write op codes
// used by the Display blocks and the map write arbiter.
package map_write_arbiter_pkg;

  localparam int DISP_NUM_POS  = 144;
  localparam int DISP_CARD_W   = 6;
  localparam int DISP_MAX_CARD = 54;
  localparam int POS_W         = 8;
  localparam int CNT_W         = 8;

  localparam logic [DISP_CARD_W-1:0] CARD_EMPTY = '0;

  typedef enum logic [1:0] {
    OP_WRITE         = 2'b00,
    OP_CLEAR         = 2'b01,
    OP_TOGGLE_SEL    = 2'b10,
    OP_CLEAR_SEL_ALL = 2'b11
  } op_e;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } grant_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } state_e;

  // Ops that address a single position must carry a position on the board.
  function automatic logic op_uses_pos(op_e op);
    return op != OP_CLEAR_SEL_ALL;
  endfunction

endpackage

// File: rtl/map_write_arbiter_if.sv
// Request/response bundle between the two map writers (game logic A,
// interboard receiver B) and the arbiter, plus the board state it publishes.
interface map_write_arbiter_if #(
  parameter int NUM_POS = map_write_arbiter_pkg::DISP_NUM_POS,
  parameter int CARD_W  = map_write_arbiter_pkg::DISP_CARD_W
);
  logic                      req_a, req_b;
  logic [1:0]                op_a, op_b;
  logic [7:0]                pos_a, pos_b;
  logic [CARD_W-1:0]         card_a, card_b;
  logic                      pend_a, pend_b;
  logic                      done_a, done_b;
  logic                      err;
  logic [NUM_POS*CARD_W-1:0] map;
  logic [NUM_POS-1:0]        sel_card;
  logic [7:0]                card_cnt;

  modport slave (
    input  req_a, req_b, op_a, op_b, pos_a, pos_b, card_a, card_b,
    output pend_a, pend_b, done_a, done_b, err, map, sel_card, card_cnt
  );

  modport master (
    output req_a, req_b, op_a, op_b, pos_a, pos_b, card_a, card_b,
    input  pend_a, pend_b, done_a, done_b, err, map, sel_card, card_cnt
  );
endinterface

// File: rtl/map_req_slot.sv
// One-entry holding slot for a map write request; refills in the same cycle
// it is released so a back-to-back requester loses nothing.
module map_req_slot
  import map_write_arbiter_pkg::*;
#(
  parameter int CARD_W = DISP_CARD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sync_clr_i,
  input  logic              req_i,
  input  logic [1:0]        op_i,
  input  logic [POS_W-1:0]  pos_i,
  input  logic [CARD_W-1:0] card_i,
  input  logic              clr_i,
  output logic              pend_o,
  output op_e               op_o,
  output logic [POS_W-1:0]  pos_o,
  output logic [CARD_W-1:0] card_o
);

  logic              pend_q, pend_d;
  op_e               op_q, op_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [CARD_W-1:0] card_q, card_d;

  always_comb begin
    pend_d = pend_q;
    op_d   = op_q;
    pos_d  = pos_q;
    card_d = card_q;
    if (clr_i) pend_d = 1'b0;
    if (req_i && (!pend_q || clr_i)) begin
      pend_d = 1'b1;
      op_d   = op_e'(op_i);
      pos_d  = pos_i;
      card_d = card_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= 1'b0;
      op_q   <= OP_WRITE;
      pos_q  <= '0;
      card_q <= '0;
    end else if (sync_clr_i) begin
      pend_q <= 1'b0;
      op_q   <= OP_WRITE;
      pos_q  <= '0;
      card_q <= '0;
    end else begin
      pend_q <= pend_d;
      op_q   <= op_d;
      pos_q  <= pos_d;
      card_q <= card_d;
    end
  end

  assign pend_o = pend_q;
  assign op_o   = op_q;
  assign pos_o  = pos_q;
  assign card_o = card_q;

endmodule

// File: rtl/map_write_arbiter.sv
// Arbitrates board-map writes from local game logic (A) and the interboard
// receiver (B), committing one request per vertical-blanking APPLY cycle.
module map_write_arbiter
  import map_write_arbiter_pkg::*;
#(
  parameter int NUM_POS  = DISP_NUM_POS,
  parameter int CARD_W   = DISP_CARD_W,
  parameter int MAX_CARD = DISP_MAX_CARD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 interboard_rst,
  input  logic                 frame_blank,
  map_write_arbiter_if.slave   bus
);

  state_e                    state_q, state_d;
  grant_e                    grant_q, grant_d;
  grant_e                    last_q, last_d;
  logic [NUM_POS*CARD_W-1:0] map_q, map_d;
  logic [NUM_POS-1:0]        sel_q, sel_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      done_a_q, done_a_d, done_b_q, done_b_d, err_q, err_d;

  logic              pend_a, pend_b, clr_a, clr_b;
  op_e               op_a_s, op_b_s, cur_op;
  logic [POS_W-1:0]  pos_a_s, pos_b_s, cur_pos;
  logic [CARD_W-1:0] card_a_s, card_b_s, cur_card, old_card;
  logic              pos_ok, req_bad;
  int                cur_idx;

  map_req_slot #(.CARD_W(CARD_W)) u_slot_a (
    .clk(clk), .rst(rst), .sync_clr_i(interboard_rst),
    .req_i(bus.req_a), .op_i(bus.op_a), .pos_i(bus.pos_a), .card_i(bus.card_a),
    .clr_i(clr_a), .pend_o(pend_a), .op_o(op_a_s), .pos_o(pos_a_s), .card_o(card_a_s)
  );

  map_req_slot #(.CARD_W(CARD_W)) u_slot_b (
    .clk(clk), .rst(rst), .sync_clr_i(interboard_rst),
    .req_i(bus.req_b), .op_i(bus.op_b), .pos_i(bus.pos_b), .card_i(bus.card_b),
    .clr_i(clr_b), .pend_o(pend_b), .op_o(op_b_s), .pos_o(pos_b_s), .card_o(card_b_s)
  );

  always_comb begin
    cur_op   = (grant_q == GNT_A) ? op_a_s   : op_b_s;
    cur_pos  = (grant_q == GNT_A) ? pos_a_s  : pos_b_s;
    cur_card = (grant_q == GNT_A) ? card_a_s : card_b_s;
    pos_ok   = int'(cur_pos) < NUM_POS;
    cur_idx  = pos_ok ? int'(cur_pos) : 0;
    old_card = map_q[cur_idx*CARD_W +: CARD_W];
    req_bad  = (op_uses_pos(cur_op) && !pos_ok) ||
               (cur_op == OP_WRITE && int'(cur_card) > MAX_CARD);
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    map_d    = map_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    done_a_d = 1'b0;
    done_b_d = 1'b0;
    err_d    = 1'b0;
    clr_a    = 1'b0;
    clr_b    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_blank && (pend_a || pend_b)) begin
          state_d = ST_APPLY;
          if (pend_a && pend_b) grant_d = (last_q == GNT_A) ? GNT_B : GNT_A;
          else                  grant_d = pend_a ? GNT_A : GNT_B;
        end
      end
      ST_APPLY: begin
        state_d = ST_IDLE;
        last_d  = grant_q;
        clr_a   = (grant_q == GNT_A);
        clr_b   = (grant_q == GNT_B);
        if (req_bad) begin
          err_d = 1'b1;
        end else begin
          done_a_d = (grant_q == GNT_A);
          done_b_d = (grant_q == GNT_B);
          case (cur_op)
            OP_WRITE: begin
              map_d[cur_idx*CARD_W +: CARD_W] = cur_card;
              if (old_card == CARD_EMPTY && cur_card != CARD_EMPTY && int'(cnt_q) < NUM_POS)
                cnt_d = cnt_q + 8'd1;
              else if (old_card != CARD_EMPTY && cur_card == CARD_EMPTY && cnt_q != '0)
                cnt_d = cnt_q - 8'd1;
            end
            OP_CLEAR: begin
              map_d[cur_idx*CARD_W +: CARD_W] = CARD_EMPTY;
              if (old_card != CARD_EMPTY && cnt_q != '0) cnt_d = cnt_q - 8'd1;
            end
            OP_TOGGLE_SEL:    sel_d[cur_idx] = ~sel_q[cur_idx];
            OP_CLEAR_SEL_ALL: sel_d = '0;
            default: ;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The interboard clear shares reset values so an in-flight APPLY is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= GNT_A;
      last_q   <= GNT_B;
      map_q    <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      err_q    <= 1'b0;
    end else if (interboard_rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= GNT_A;
      last_q   <= GNT_B;
      map_q    <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      map_q    <= map_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      done_a_q <= done_a_d;
      done_b_q <= done_b_d;
      err_q    <= err_d;
    end
  end

  assign bus.pend_a   = pend_a;
  assign bus.pend_b   = pend_b;
  assign bus.done_a   = done_a_q;
  assign bus.done_b   = done_b_q;
  assign bus.err      = err_q;
  assign bus.map      = map_q;
  assign bus.sel_card = sel_q;
  assign bus.card_cnt = cnt_q;

endmodule

// File: tb/tb_map_write_arbiter.sv
// Scoreboard bench for map_write_arbiter: directed scenarios plus randomized
// traffic, predicted by a position-array board model.
module tb_map_write_arbiter;

  localparam int NP = 144;
  localparam int CW = 6;
  localparam int MC = 54;

  typedef struct {
    logic [1:0]    op;
    logic [7:0]    pos;
    logic [CW-1:0] card;
  } req_t;

  typedef struct {
    logic             da;
    logic             db;
    logic             er;
    logic [NP*CW-1:0] map;
    logic [NP-1:0]    sel;
    logic [7:0]       cnt;
    int               cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ibr = 1'b0;
  logic blank = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t          sb[$];
  exp_t          e_mon;
  logic [CW-1:0] map_m [NP];
  logic          sel_m [NP];
  int            last_m = 1;

  map_write_arbiter_if #(.NUM_POS(NP), .CARD_W(CW)) bus ();

  map_write_arbiter #(.NUM_POS(NP), .CARD_W(CW), .MAX_CARD(MC)) dut (
    .clk(clk), .rst(rst_n), .interboard_rst(ibr), .frame_blank(blank), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [1023:0] got, input logic [1023:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NP; i++) begin
      map_m[i] = '0;
      sel_m[i] = 1'b0;
    end
    last_m = 1;
  endfunction

  function automatic exp_t snapshot();
    exp_t e;
    int   n = 0;
    e.da = 0; e.db = 0; e.er = 0; e.cyc = -1;
    for (int i = 0; i < NP; i++) begin
      e.map[i*CW +: CW] = map_m[i];
      e.sel[i] = sel_m[i];
      if (map_m[i] != 0) n++;
    end
    e.cnt = 8'(n);
    return e;
  endfunction

  // Apply one committed request to the board model and queue its expected response.
  function automatic void model_commit(input int who, input req_t r, input int exp_cyc);
    exp_t e;
    logic bad;
    bad = (r.op != 2'b11 && int'(r.pos) >= NP) || (r.op == 2'b00 && int'(r.card) > MC);
    if (!bad) begin
      case (r.op)
        2'b00: map_m[r.pos] = r.card;
        2'b01: map_m[r.pos] = '0;
        2'b10: sel_m[r.pos] = !sel_m[r.pos];
        default: for (int i = 0; i < NP; i++) sel_m[i] = 1'b0;
      endcase
    end
    last_m = who;
    e = snapshot();
    e.er  = bad;
    e.da  = !bad && who == 0;
    e.db  = !bad && who == 1;
    e.cyc = exp_cyc;
    sb.push_back(e);
  endfunction

  task automatic drive(input bit en_a, input req_t ra, input bit en_b, input req_t rb);
    bus.req_a = en_a; bus.op_a = ra.op; bus.pos_a = ra.pos; bus.card_a = ra.card;
    bus.req_b = en_b; bus.op_b = rb.op; bus.pos_b = rb.pos; bus.card_b = rb.card;
    @(posedge clk); #1;
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
  endtask

  // With blank high and the arbiter idle: one request lands 3 cycles later, a
  // contending second request 2 cycles after that.
  task automatic issue(input bit en_a, input req_t ra, input bit en_b, input req_t rb);
    int n, first;
    n = cyc;
    if (en_a && en_b) begin
      first = (last_m == 0) ? 1 : 0;
      model_commit(first, first == 0 ? ra : rb, n + 3);
      model_commit(1 - first, first == 0 ? rb : ra, n + 5);
    end else if (en_a) model_commit(0, ra, n + 3);
    else if (en_b)     model_commit(1, rb, n + 3);
    drive(en_a, ra, en_b, rb);
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      if (sb.size() == 0 && !bus.pend_a && !bus.pend_b) return;
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL drain_timeout: got %0d outstanding responses expected 0", sb.size());
    sb.delete();
  endtask

  function automatic req_t rnd_req();
    req_t r;
    r.op = 2'($urandom_range(0, 3));
    case ($urandom_range(0, 9))
      0:       r.pos = 8'($urandom_range(NP, 255));
      1, 2, 3: r.pos = 8'($urandom_range(0, NP - 1));
      default: r.pos = 8'($urandom_range(0, 11));
    endcase
    case ($urandom_range(0, 9))
      0:       r.card = CW'($urandom_range(MC + 1, 63));
      1, 2:    r.card = '0;
      default: r.card = CW'($urandom_range(1, MC));
    endcase
    return r;
  endfunction

  function automatic req_t mk(input logic [1:0] op, input logic [7:0] pos, input logic [CW-1:0] card);
    req_t r;
    r.op = op; r.pos = pos; r.card = card;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && (bus.done_a || bus.done_b || bus.err)) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got done_a=%0b done_b=%0b err=%0b expected none",
                 bus.done_a, bus.done_b, bus.err);
      end else begin
        e_mon = sb.pop_front();
        chk("done_a", 1024'(bus.done_a), 1024'(e_mon.da));
        chk("done_b", 1024'(bus.done_b), 1024'(e_mon.db));
        chk("err", 1024'(bus.err), 1024'(e_mon.er));
        chk("map", 1024'(bus.map), 1024'(e_mon.map));
        chk("sel_card", 1024'(bus.sel_card), 1024'(e_mon.sel));
        chk("card_cnt", 1024'(bus.card_cnt), 1024'(e_mon.cnt));
        if (e_mon.cyc >= 0) chk("latency_cycle", 1024'(cyc), 1024'(e_mon.cyc));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    req_t z, ra, rb;
    exp_t s;
    int   m, first;
    z = mk(2'b00, 8'd0, '0);
    bus.req_a = 0; bus.req_b = 0;
    bus.op_a = 0; bus.op_b = 0; bus.pos_a = 0; bus.pos_b = 0; bus.card_a = 0; bus.card_b = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    chk("reset_map", 1024'(bus.map), 1024'(0));
    chk("reset_sel", 1024'(bus.sel_card), 1024'(0));
    chk("reset_cnt", 1024'(bus.card_cnt), 1024'(0));
    chk("reset_pend", 1024'({bus.pend_a, bus.pend_b}), 1024'(0));
    chk("reset_pulses", 1024'({bus.done_a, bus.done_b, bus.err}), 1024'(0));

    blank = 1'b1;
    issue(1, mk(2'b00, 8'd5, 6'd12), 0, z);
    drain();
    chk("pos5_card", 1024'(bus.map[35:30]), 1024'(12));

    issue(1, mk(2'b00, 8'd150, 6'd3), 0, z);  drain();
    issue(1, mk(2'b00, 8'd3, 6'd60), 0, z);   drain();

    issue(1, mk(2'b10, 8'd7, 6'd0), 0, z);    drain();
    issue(0, z, 1, mk(2'b10, 8'd7, 6'd0));    drain();
    issue(1, mk(2'b10, 8'd9, 6'd0), 0, z);    drain();
    issue(0, z, 1, mk(2'b11, 8'd200, 6'd63)); drain();

    // Both requesters queue while blank is low; blank then opens the window.
    blank = 1'b0;
    ra = mk(2'b00, 8'd10, 6'd33);
    rb = mk(2'b00, 8'd11, 6'd44);
    drive(1, ra, 1, rb);
    repeat (3) begin @(posedge clk); #1; end
    s = snapshot();
    chk("queued_pend", 1024'({bus.pend_a, bus.pend_b}), 1024'(2'b11));
    chk("queued_map_hold", 1024'(bus.map), 1024'(s.map));
    m = cyc;
    first = (last_m == 0) ? 1 : 0;
    model_commit(first, first == 0 ? ra : rb, m + 2);
    model_commit(1 - first, first == 0 ? rb : ra, m + 4);
    blank = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("pend_order", 1024'({bus.pend_a, bus.pend_b}), 1024'(first == 0 ? 2'b01 : 2'b10));
    drain();

    // Second req_a while the slot is still full must be dropped.
    blank = 1'b0;
    ra = mk(2'b00, 8'd20, 6'd7);
    drive(1, ra, 0, z);
    drive(1, mk(2'b00, 8'd21, 6'd8), 0, z);
    m = cyc;
    model_commit(0, ra, m + 2);
    blank = 1'b1;
    drain();

    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 2))
        0:       issue(1, rnd_req(), 0, z);
        1:       issue(0, z, 1, rnd_req());
        default: issue(1, rnd_req(), 1, rnd_req());
      endcase
      drain();
    end

    // Interboard clear lands during the APPLY cycle of a write.
    issue(1, mk(2'b00, 8'd0, 6'd1), 0, z);
    void'(sb.pop_back());
    @(posedge clk); #1;
    ibr = 1'b1;
    bus.req_b = 1'b1; bus.op_b = 2'b00; bus.pos_b = 8'd2; bus.card_b = 6'd2;
    @(posedge clk); #1;
    ibr = 1'b0;
    bus.req_b = 1'b0;
    model_reset();
    repeat (3) begin @(posedge clk); #1; end
    chk("ibr_map", 1024'(bus.map), 1024'(0));
    chk("ibr_sel", 1024'(bus.sel_card), 1024'(0));
    chk("ibr_cnt", 1024'(bus.card_cnt), 1024'(0));
    chk("ibr_pend", 1024'({bus.pend_a, bus.pend_b}), 1024'(0));

    issue(1, mk(2'b00, 8'd1, 6'd5), 1, mk(2'b00, 8'd2, 6'd6));
    drain();

    s = snapshot();
    chk("final_map", 1024'(bus.map), 1024'(s.map));
    chk("final_sel", 1024'(bus.sel_card), 1024'(s.sel));
    chk("final_cnt", 1024'(bus.card_cnt), 1024'(s.cnt));
    chk("scoreboard_empty", 1024'(sb.size()), 1024'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/map_write_arbiter.md
MAP_WRITE_ARBITER -- requirements
Module: map_write_arbiter

Interface
REQ-001 Parameters: NUM_POS, default 144, number of board positions (8x18); CARD_W, default 6, card code width; MAX_CARD, default 54, highest legal card code.
REQ-002 Ports: clk, input, 1, system clock.
REQ-003 Ports: rst, input, 1, reset, asynchronous and active-low.
REQ-004 Ports: interboard_rst, input, 1, synchronous clear, active-high.
REQ-005 Ports: frame_blank, input, 1, high while the VGA raster is in vertical blanking.
REQ-006 Ports: req_a and req_b, input, 1 each, one-cycle request pulses; A is the local game logic, B is the interboard receiver.
REQ-007 Ports: op_a and op_b, input, 2 each, operation code: 00 WRITE, 01 CLEAR, 10 TOGGLE_SEL, 11 CLEAR_SEL_ALL.
REQ-008 Ports: pos_a and pos_b, input, 8 each, board position 0..NUM_POS-1.
REQ-009 Ports: card_a and card_b, input, CARD_W each, card code; 0 means empty.
REQ-010 Ports: pend_a and pend_b, output, 1 each, high while that requester's holding slot is occupied.
REQ-011 Ports: done_a and done_b, output, 1 each, one-cycle commit pulse.
REQ-012 Ports: err, output, 1, one-cycle pulse when a granted request is rejected.
REQ-013 Ports: map, output, NUM_POS*CARD_W; position p occupies bits [6p+5:6p].
REQ-014 Ports: sel_card, output, NUM_POS; bit p is the selection flag for position p.
REQ-015 Ports: card_cnt, output, 8, number of non-empty positions.

Function
REQ-016 Each requester SHALL own a one-entry holding slot that captures {op, pos, card} on a req pulse when the slot is empty; pend_x SHALL rise in the next cycle.
REQ-017 A req pulse while pend_x is high SHALL be ignored, except in the APPLY cycle that clears that slot, where the new request SHALL be captured.
REQ-018 The FSM SHALL have the states IDLE and APPLY.
REQ-019 IDLE to APPLY: frame_blank is high and at least one pend_x is high; the winner SHALL be latched on this transition.
REQ-020 APPLY to IDLE: unconditional after one cycle; APPLY SHALL complete even if frame_blank falls during it.
REQ-021 Arbitration SHALL be round-robin using a last_grant bit; a single pending requester is always granted; when both are pending, the requester not granted last wins.
REQ-022 In APPLY, the granted operation SHALL be committed and the winner's slot cleared; map, sel_card and card_cnt SHALL reflect the commit, and done_x or err SHALL pulse, in the following cycle.
REQ-023 Latency: with frame_blank high and the FSM in IDLE, a req pulse at cycle N SHALL produce done_x and the updated map at cycle N+3.
REQ-024 WRITE SHALL store card at pos; card_cnt SHALL be +1 for an empty-to-nonzero write, -1 for a nonzero-to-0 write, and unchanged otherwise.
REQ-025 CLEAR SHALL set pos to 0 and decrement card_cnt only if the position was occupied.
REQ-026 TOGGLE_SEL SHALL invert sel_card[pos]; CLEAR_SEL_ALL SHALL zero all of sel_card and ignore pos and card.
REQ-027 A pos >= NUM_POS (ops 00, 01 and 10) or card > MAX_CARD (WRITE) SHALL cause no state change and an err pulse instead of done_x; the slot SHALL still be cleared.
REQ-028 No commit SHALL occur outside APPLY; while frame_blank is low, requests SHALL accumulate in their slots and nothing else.
REQ-029 card_cnt SHALL saturate at 0 and at NUM_POS and never wrap.

Reset
REQ-030 On rst low: map = 0, sel_card = 0, card_cnt = 0, both slots empty, pend/done/err = 0, state = IDLE, last_grant = B.
REQ-031 interboard_rst high at a clock edge SHALL apply the same values synchronously, aborting any APPLY with no commit and no done or err pulse; req pulses in that cycle SHALL be dropped.

Structure
REQ-032 The op codes, NUM_POS, CARD_W, MAX_CARD and the empty code 0 SHALL live in the shared display package used by the Display blocks.
REQ-033 The holding slot SHALL be one sub-module, map_req_slot, instantiated twice; the FSM, arbiter and commit datapath SHALL stay in map_write_arbiter.

Verification
REQ-034 Blank high, req_a WRITE pos 5 card 12 at cycle N: map[35:30] = 12, card_cnt = 1 and done_a pulse at N+3.
REQ-035 Blank low, req_a and req_b both queued, then blank raised: A commits first, B commits two cycles later; pend_a and pend_b fall in order.
REQ-036 WRITE pos 150, then WRITE pos 3 card 60: two err pulses; map and card_cnt unchanged.
REQ-037 TOGGLE_SEL pos 7 twice, then TOGGLE_SEL pos 9, then CLEAR_SEL_ALL: sel_card[7] goes 1 then 0; sel_card[9] = 1 then all bits 0.
REQ-038 interboard_rst asserted during APPLY of WRITE pos 0 card 1: map stays 0, no done_a, pend_a = 0, state = IDLE.
REQ-039 Second req_a while pend_a is high outside APPLY: ignored; one done_a only, holding the first request's data.
